// File: rtl/spi_slave_mode.sv
// SPI slave, all CPOL/CPHA modes; rx_valid rises SYNC_STAGES+1 clk edges after the final sample-edge sclk capture.
// TX/RX use valid/ready; an unaccepted RX word is overwritten (rx_overrun), an empty TX holding register sends zeros (tx_underrun).
`timescale 1ns/1ps
module spi_slave_mode #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             ss_n,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             frame_abort
);

    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
    localparam logic           IDLE_SCLK = (CPOL != 0);
    localparam logic [0:0]     IDLE      = 1'b0;
    localparam logic [0:0]     ACTIVE    = 1'b1;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_hist, ss_hist;
    logic [0:0]             state;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       tx_shift, tx_hold, rx_shift;
    logic                   rx_done;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{IDLE_SCLK}};
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_hist <= IDLE_SCLK;
            ss_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            ss_hist   <= ss_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, mosi_s, ss_s;
    logic sclk_edge, lead_edge, trail_edge, sample_edge, drive_edge;
    logic ss_fall, ss_rise, abort, load, capture;
    logic [WIDTH-1:0] load_word;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];

    assign sclk_edge   = (sclk_s != sclk_hist) && !ss_s && (state == ACTIVE);
    assign lead_edge   = sclk_edge && (sclk_hist == IDLE_SCLK);
    assign trail_edge  = sclk_edge && (sclk_s == IDLE_SCLK);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign drive_edge  = (CPHA != 0) ? lead_edge : trail_edge;

    assign ss_fall = ss_hist && !ss_s && (state == IDLE);
    assign ss_rise = !ss_hist && ss_s && (state == ACTIVE);
    assign abort   = ss_rise && (bit_cnt != '0);

    // With CPHA=0 a drive edge seen at bit_cnt==0 is the one right after a word's last sample.
    assign load      = ((CPHA == 0) && ss_fall) || (drive_edge && (bit_cnt == '0));
    assign capture   = tx_valid && tx_ready;
    assign load_word = tx_ready ? '0 : tx_hold;

    assign miso_oe = (state == ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            rx_shift    <= '0;
            rx_done     <= 1'b0;
            miso        <= 1'b0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_done     <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= load && tx_ready;
            frame_abort <= abort;

            if (ss_fall) begin
                state <= ACTIVE;
            end else if (ss_rise) begin
                state <= IDLE;
            end

            if (abort) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample_edge) begin
                rx_shift <= shift_in(rx_shift, mosi_s);
                bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
                rx_done  <= (bit_cnt == LAST_BIT);
            end

            if (abort) begin
                tx_shift <= '0;
            end else if (load) begin
                miso     <= first_bit(load_word);
                tx_shift <= shift_out(load_word);
            end else if (drive_edge) begin
                miso     <= first_bit(tx_shift);
                tx_shift <= shift_out(tx_shift);
            end

            // A same-cycle load and capture: old word goes out, new word stays held.
            if (capture) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end else if (load) begin
                tx_ready <= 1'b1;
            end

            if (rx_done) begin
                rx_data    <= rx_shift;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid && !rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_mode.sv
// Randomised bench for spi_slave_mode across modes 0-3 and LSB-first, scoreboarded RX and master-side MISO checks.
`timescale 1ns/1ps
module tb_spi_slave_mode;

    localparam int NDUT = 5;
    localparam int H    = 6;

    logic            clk;
    logic            rst;
    logic [NDUT-1:0] sclk_v;
    logic [NDUT-1:0] ss_n_v;
    logic            mosi;
    logic [7:0]      tx_data;
    logic [NDUT-1:0] tx_valid_v;
    logic [NDUT-1:0] rx_ready_v;

    wire  [NDUT-1:0] miso_v, miso_oe_v, tx_ready_v, rx_valid_v;
    wire  [NDUT-1:0] rx_overrun_v, tx_underrun_v, frame_abort_v;
    wire  [7:0]      rx_data_v [NDUT];

    genvar g;
    for (g = 0; g < NDUT; g++) begin : g_dut
        spi_slave_mode #(
            .WIDTH      (8),
            .CPOL       ((g == 2 || g == 3) ? 1 : 0),
            .CPHA       ((g == 1 || g == 3) ? 1 : 0),
            .MSB_FIRST  ((g == 4) ? 0 : 1),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .sclk       (sclk_v[g]),
            .mosi       (mosi),
            .ss_n       (ss_n_v[g]),
            .miso       (miso_v[g]),
            .miso_oe    (miso_oe_v[g]),
            .tx_data    (tx_data),
            .tx_valid   (tx_valid_v[g]),
            .tx_ready   (tx_ready_v[g]),
            .rx_data    (rx_data_v[g]),
            .rx_valid   (rx_valid_v[g]),
            .rx_ready   (rx_ready_v[g]),
            .rx_overrun (rx_overrun_v[g]),
            .tx_underrun(tx_underrun_v[g]),
            .frame_abort(frame_abort_v[g])
        );
    end

    int cur;
    int total, bad;
    int n_ovr, n_und, n_abt;

    logic [7:0] exp_rx [$];
    logic [7:0] feed_q [$];
    logic [7:0] mo_w [4];
    logic [7:0] tx_w [4];
    bit         sup  [4];

    wire       m_miso     = miso_v[cur];
    wire       m_miso_oe  = miso_oe_v[cur];
    wire       m_tx_ready = tx_ready_v[cur];
    wire       m_rx_valid = rx_valid_v[cur];
    wire       m_rx_ready = rx_ready_v[cur];
    wire [7:0] m_rx_data  = rx_data_v[cur];
    wire       m_ovr      = rx_overrun_v[cur];
    wire       m_und      = tx_underrun_v[cur];
    wire       m_abt      = frame_abort_v[cur];

    function automatic bit cfg_cpol(input int c); return (c == 2 || c == 3); endfunction
    function automatic bit cfg_cpha(input int c); return (c == 1 || c == 3); endfunction
    function automatic bit cfg_msb(input int c);  return (c != 4);           endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d got=%0h exp=%0h", name, cur, got, exp);
        end
    endtask

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation did not finish");
    end

    // Scoreboard monitor: every accepted RX word is popped and compared; status pulses are counted.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (m_rx_valid && m_rx_ready) begin
                    if (exp_rx.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_extra dut=%0d got=%0h exp=none", cur, m_rx_data);
                    end else begin
                        chk("rx_data", 32'(m_rx_data), 32'(exp_rx.pop_front()));
                    end
                end
                if (m_ovr) n_ovr++;
                if (m_und) n_und++;
                if (m_abt) n_abt++;
            end
        end
    end

    task automatic tx_push(input logic [7:0] w);
        int n;
        n = 0;
        @(negedge clk);
        tx_data         = w;
        tx_valid_v[cur] = 1'b1;
        while (!m_tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_valid_v[cur] = 1'b0;
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL tx_push_timeout dut=%0d got=tx_ready_low exp=tx_ready_high", cur);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (feed_q.size() != 0) tx_push(feed_q.pop_front());
        end
    end

    // SPI master: drives pins per mode, reassembles miso in the DUT's bit order.
    task automatic spi_xfer(input int nw, input int stop_bits, input bit raise);
        bit p, ph, msb, halt;
        int bits, bpos;
        logic [7:0] got;
        p = cfg_cpol(cur); ph = cfg_cpha(cur); msb = cfg_msb(cur);
        bits = 0; halt = 1'b0;
        if (sup[0]) tx_push(tx_w[0]);
        ss_n_v[cur] = 1'b0;
        wait_h();
        if (stop_bits == 0)
            chk("tx_ready_after_fall", 32'(m_tx_ready), (ph == 1'b0) ? 32'd1 : 32'(!sup[0]));
        for (int k = 0; k < nw && !halt; k++) begin
            got = '0;
            for (int i = 0; i < 8 && !halt; i++) begin
                bpos = msb ? 7 - i : i;
                if (!ph) begin
                    mosi = mo_w[k][bpos];
                    wait_h();
                    got[bpos] = m_miso;
                    if (i == 0) chk("miso_oe", 32'(m_miso_oe), 32'd1);
                    sclk_v[cur] = ~p;
                    wait_h();
                    sclk_v[cur] = p;
                end else begin
                    sclk_v[cur] = ~p;
                    mosi = mo_w[k][bpos];
                    wait_h();
                    got[bpos] = m_miso;
                    if (i == 0) chk("miso_oe", 32'(m_miso_oe), 32'd1);
                    sclk_v[cur] = p;
                    wait_h();
                end
                if (i == 2 && k + 1 < nw && sup[k+1]) feed_q.push_back(tx_w[k+1]);
                bits++;
                if (stop_bits != 0 && bits == stop_bits) halt = 1'b1;
            end
            if (!halt) chk("miso_word", 32'(got), sup[k] ? 32'(tx_w[k]) : 32'd0);
        end
        wait_h();
        if (raise) ss_n_v[cur] = 1'b1;
        wait_h();
    endtask

    // Reference: every word is delivered unless consumer stalls (only the last survives);
    // CPHA=0 loads once per word plus once at frame start, CPHA=1 once per word.
    task automatic run_frame(input int nw, input bit ready_low);
        int o0, u0, a0, eu;
        o0 = n_ovr; u0 = n_und; a0 = n_abt;
        eu = cfg_cpha(cur) ? 0 : 1;
        for (int k = 0; k < nw; k++) if (!sup[k]) eu++;
        if (ready_low) begin
            exp_rx.push_back(mo_w[nw-1]);
            rx_ready_v[cur] = 1'b0;
        end else begin
            for (int k = 0; k < nw; k++) exp_rx.push_back(mo_w[k]);
        end
        spi_xfer(nw, 0, 1'b1);
        if (ready_low) begin
            chk("held_rx_valid", 32'(m_rx_valid), 32'd1);
            chk("held_rx_data", 32'(m_rx_data), 32'(mo_w[nw-1]));
            repeat (4) @(negedge clk);
            rx_ready_v[cur] = 1'b1;
        end
        repeat (20) @(negedge clk);
        chk("overrun_cnt", 32'(n_ovr - o0), ready_low ? 32'(nw - 1) : 32'd0);
        chk("underrun_cnt", 32'(n_und - u0), 32'(eu));
        chk("abort_cnt", 32'(n_abt - a0), 32'd0);
        chk("rx_drained", 32'(exp_rx.size()), 32'd0);
        exp_rx.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_miso", 32'(m_miso), 32'd0);
        chk("rst_miso_oe", 32'(m_miso_oe), 32'd0);
        chk("rst_tx_ready", 32'(m_tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(m_rx_valid), 32'd0);
        chk("rst_rx_data", 32'(m_rx_data), 32'd0);
        chk("rst_pulses", 32'({m_ovr, m_und, m_abt}), 32'd0);
    endtask

    task automatic rand_words(input int nw);
        for (int k = 0; k < nw; k++) begin
            mo_w[k] = 8'($urandom_range(0, 255));
            tx_w[k] = 8'($urandom_range(0, 255));
            sup[k]  = 1'b1;
        end
    endtask

    initial begin
        int o0, u0, a0;
        total = 0; bad = 0; n_ovr = 0; n_und = 0; n_abt = 0; cur = 0;
        rst = 1'b1;
        sclk_v = 5'b01100;
        ss_n_v = '1;
        mosi = 1'b0;
        tx_data = '0;
        tx_valid_v = '0;
        rx_ready_v = '1;
        repeat (4) @(negedge clk);
        for (int c = 0; c < NDUT; c++) begin
            cur = c;
            #1;
            check_reset_outputs();
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int c = 0; c < NDUT; c++) begin
            cur = c;

            mo_w[0] = 8'h3C; tx_w[0] = 8'hA5; sup[0] = 1'b1;
            run_frame(1, 1'b0);

            rand_words(3);
            mo_w[0] = 8'h11; mo_w[1] = 8'h22; mo_w[2] = 8'h33;
            run_frame(3, 1'b0);

            rand_words(2);
            run_frame(2, 1'b1);

            rand_words(1);
            sup[0] = 1'b0;
            run_frame(1, 1'b0);

            rand_words(1);
            sup[0] = 1'b0;
            o0 = n_ovr; u0 = n_und; a0 = n_abt;
            spi_xfer(1, 3, 1'b1);
            repeat (20) @(negedge clk);
            chk("abort_pulse", 32'(n_abt - a0), 32'd1);
            chk("abort_underrun", 32'(n_und - u0), 32'd1);
            chk("abort_overrun", 32'(n_ovr - o0), 32'd0);
            chk("abort_no_rx", 32'(m_rx_valid), 32'd0);

            rand_words(1);
            mo_w[0] = 8'h5A;
            run_frame(1, 1'b0);

            rand_words(1);
            spi_xfer(1, 3, 1'b0);
            a0 = n_abt;
            rst = 1'b1;
            ss_n_v[cur] = 1'b1;
            sclk_v[cur] = cfg_cpol(cur);
            @(negedge clk);
            #1;
            check_reset_outputs();
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (10) @(negedge clk);
            chk("no_abort_on_rst", 32'(n_abt - a0), 32'd0);

            rand_words(1);
            run_frame(1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_mode.md
Name: spi_slave_mode

Overview:
- Parametrised SPI slave supporting all four SPI modes (CPOL/CPHA), configurable word width and bit order, and slave-select framing.
- Adds valid/ready handshakes on the TX and RX word interfaces, plus overrun, underrun and abort status pulses.
- Sits between the external SPI pins and the internal register/command logic.
- All logic runs in the clk domain. SPI pins are oversampled through synchronisers.

Parameters:
- WIDTH, 8, bits per SPI word (>=2); same width for TX and RX.
- CPOL, 0, idle level of sclk.
- CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
- MSB_FIRST, 1, 1 = shift MSB first; 0 = shift LSB first.
- SYNC_STAGES, 2, flops in each pin synchroniser (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sclk  in  1  SPI clock pin (asynchronous)
- mosi  in  1  SPI data in (asynchronous)
- ss_n  in  1  slave select, active-low (asynchronous)
- miso  out  1  SPI data out
- miso_oe  out  1  miso output enable (pad tristate control)
- tx_data  in  WIDTH  word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX holding register empty
- rx_data  out  WIDTH  last received word
- rx_valid  out  1  rx_data valid, held until accepted
- rx_ready  in  1  consumer accepts rx_data
- rx_overrun  out  1  1-cycle pulse: word completed while rx_valid was still high
- tx_underrun  out  1  1-cycle pulse: word load with TX holding register empty
- frame_abort  out  1  1-cycle pulse: ss_n rose mid-word

Behaviour:
- Synchronisers
  - sclk, mosi and ss_n each pass through SYNC_STAGES flops, plus one history flop for sclk and ss_n.
  - Edge pulses are derived from the last two stages. mosi is sampled from its synchronised copy, so it stays aligned with sclk.
  - Required sclk half-period: >= SYNC_STAGES+2 clk cycles.
- Edge definitions
  - Leading edge = sclk leaving the CPOL level; trailing edge = sclk returning to it.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. Drive edge = the other edge.
  - sclk edges are ignored while synchronised ss_n is high.
- Frame state machine
  - States: IDLE (ss_n high) and ACTIVE (ss_n low).
  - IDLE->ACTIVE on synchronised ss_n fall. ACTIVE->IDLE on ss_n rise.
  - bit_cnt ($clog2(WIDTH) bits) counts sample edges 0..WIDTH-1 and wraps to 0, so back-to-back words are supported without ss_n toggling.
- Word load: moves the holding register into the TX shift register and sets tx_ready=1 in the same cycle.
  - CPHA=0: load at the ss_n fall, and at the drive edge following the WIDTH-th sample edge. The first bit appears on miso in that same cycle.
  - CPHA=1: load at the drive edge when bit_cnt==0; the first bit is driven there.
  - Holding register empty at load: shift register is loaded with all zeros and tx_underrun pulses.
- TX handshake
  - tx_valid & tx_ready captures tx_data and drops tx_ready the next cycle.
  - A load and a capture in the same cycle are both honoured: the old word goes to the shift register, the new word is held, tx_ready=0.
- Drive edges
  - At each non-load drive edge, miso takes the next bit in MSB_FIRST order.
  - miso_oe = 1 only in ACTIVE. miso holds its value while in IDLE.
- RX
  - At each sample edge, mosi shifts into the RX shift register, MSB_FIRST order.
  - On the WIDTH-th sample edge: rx_data <= assembled word, rx_valid <= 1, one cycle after the edge pulse.
  - If rx_valid was 1 and not accepted that cycle, the new word overwrites rx_data and rx_overrun pulses.
  - rx_valid & rx_ready clears rx_valid. A completion in the same cycle wins: rx_valid stays 1 with the new data and no overrun.
- Abort: ss_n rise with bit_cnt != 0
  - frame_abort pulses; bit_cnt and both shift registers clear; the partial RX word is discarded.
  - The holding register keeps its contents. A loaded-but-unfinished TX word is lost.
- Latency: rx_valid rises SYNC_STAGES+1 clk edges after the clk edge that first captures the final sample-edge sclk level.
- Reset (rst=1, synchronous)
  - Outputs: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, all pulses 0.
  - Internal: bit_cnt=0, synchronisers = CPOL / 0 / 1 for sclk / mosi / ss_n, state IDLE.
  - Reset mid-frame abandons the frame without a frame_abort pulse.

Test Plan:
- Mode 0, WIDTH=8, MSB_FIRST=1: preload tx 0xA5, master sends 0x3C -> miso shows 1,0,1,0,0,1,0,1; one rx_valid with rx_data=0x3C; tx_ready high after ss_n fall.
- Modes 1/2/3 and MSB_FIRST=0, same words -> correct edge usage in each mode; LSB-first run returns 0x3C and transmits 0xA5 LSB first.
- Back-to-back: 3 words 0x11,0x22,0x33 in one ss_n low period, tx fed via handshake -> three rx_valid pulses; miso continuous with no gap bit.
- Overrun/underrun: rx_ready=0 across 2 words -> rx_overrun pulse, rx_data = second word. No tx preload -> miso all zeros and tx_underrun pulse at ss_n fall.
- Abort: ss_n rises after 3 bits -> frame_abort pulse, no rx_valid. Next frame with 0x5A -> rx_data=0x5A, bit alignment restored.
- Reset asserted mid-word -> all outputs at reset values next cycle; the following full frame is received correctly.
